led_pio_blink: RTL and testbench
================================

LED_PIO_BLINK -- requirements
Module: led_pio_blink

Interface
REQ-001 Parameter WIDTH, default 9, number of output bits (1..32).
REQ-002 Parameter RESET_VALUE, default 0, DATA register value after reset (WIDTH bits).
REQ-003 Parameter PERIOD_W, default 24, width of PERIOD register and blink counter (1..32).
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port address  input  3  Avalon-MM word address.
REQ-007 Port chipselect  input  1  slave select.
REQ-008 Port write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 Port writedata  input  32  write data.
REQ-010 Port readdata  output  32  read data, zero-extended.
REQ-011 Port out_port  output  WIDTH  driven LED/pin outputs.

Function
REQ-012 Register map SHALL be: 0 DATA (rw), 1 BLINK_EN (rw), 2 PERIOD (rw), 3 OUTSET (wo), 4 OUTCLEAR (wo), 5 STATUS (ro); addresses 6-7 reserved.
REQ-013 Write SHALL occur when chipselect=1 and write_n=0, taking effect on that rising edge.
REQ-014 Write data bits above WIDTH (PERIOD_W for PERIOD) SHALL be ignored.
REQ-015 OUTSET write SHALL set DATA bits where writedata=1 (DATA |= wd); OUTCLEAR write SHALL clear them (DATA &= ~wd).
REQ-016 Writes to STATUS and reserved addresses SHALL have no effect.
REQ-017 readdata SHALL be combinational from address (zero wait states): DATA, BLINK_EN, PERIOD, 0 for OUTSET/OUTCLEAR, STATUS = {31'b0, phase}, 0 for reserved.
REQ-018 Blink counter SHALL increment every cycle; when counter == PERIOD it SHALL wrap to 0 and phase SHALL toggle on the same edge.
REQ-019 Half-period SHALL be PERIOD+1 cycles; PERIOD=0 SHALL toggle phase every cycle.
REQ-020 A write to PERIOD SHALL load the new value and force counter=0, phase=0 on that edge, overriding any wrap in the same cycle.
REQ-021 out_port SHALL be registered: out_port <= DATA_next & ~(BLINK_EN_next & {WIDTH{phase_next}}), i.e. 1-cycle latency from any register write to pin.
REQ-022 Bits with BLINK_EN=0 SHALL follow DATA unchanged; bits with BLINK_EN=1 SHALL show DATA when phase=0 and 0 when phase=1.
REQ-023 Simultaneous register write and phase toggle in one cycle SHALL both take effect; out_port reflects both after that edge.
REQ-024 Counter SHALL run regardless of BLINK_EN so all blinking bits stay phase-aligned.

Reset
REQ-025 While reset=1 on a rising edge: DATA=RESET_VALUE, BLINK_EN=0, PERIOD=all ones, counter=0, phase=0, out_port=RESET_VALUE.
REQ-026 Reset SHALL take priority over any concurrent write; a write in the reset cycle SHALL be lost.
REQ-027 Reset asserted mid-blink SHALL restart counter and phase from 0 on the next deassertion.
REQ-028 readdata SHALL depend only on address and register state, not on reset directly.

Verification
REQ-029 Reset, write DATA=0x1A5 -> next edge out_port=0x1A5, read addr0=0x000001A5; write 0xFFFFFFFF -> DATA=0x1FF.
REQ-030 DATA=0x0F0, OUTSET 0x003 then OUTCLEAR 0x030 -> out_port 0x0F3 then 0x0C3; read addr3/addr4 = 0.
REQ-031 PERIOD=3, BLINK_EN=0x001, DATA=0x101 -> bit0 toggles every 4 cycles, bit8 constant 1, STATUS tracks phase.
REQ-032 PERIOD=0, BLINK_EN=0x1FF, DATA=0x1FF -> out_port alternates 0x1FF/0x000 each cycle.
REQ-033 Write PERIOD=5 on the exact cycle counter==old PERIOD -> no toggle, phase=0, next toggle 6 cycles later.
REQ-034 Assert reset mid-blink with concurrent DATA write -> registers at reset values, write discarded, out_port=RESET_VALUE.

Source files
------------

// File: rtl/led_pio_blink.sv
// led_pio_blink: Avalon-MM LED PIO with per-bit blink enable and a shared blink timer.
module led_pio_blink #(
  parameter int WIDTH = 9,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int PERIOD_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  logic [WIDTH-1:0] data, blink_en, data_nxt, blink_nxt, wd;
  logic [PERIOD_W-1:0] period, cnt, period_nxt, cnt_nxt;
  logic phase, phase_nxt, wr, per_wr, wrap, unused_wd;
  assign wr = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];
  assign per_wr = wr && address == 3'd2;
  assign wrap = cnt == period;
  assign unused_wd = ^writedata;
  always_comb begin
    data_nxt = (wr && address == 3'd0) ? wd :
               (wr && address == 3'd3) ? data | wd :
               (wr && address == 3'd4) ? data & ~wd : data;
    blink_nxt = (wr && address == 3'd1) ? wd : blink_en;
    period_nxt = per_wr ? writedata[PERIOD_W-1:0] : period;
    // a PERIOD write restarts the timer and wins over a wrap in the same cycle
    cnt_nxt = (per_wr || wrap) ? '0 : cnt + PERIOD_W'(1);
    phase_nxt = per_wr ? 1'b0 : wrap ? ~phase : phase;
  end
  always_comb begin
    readdata = '0;
    readdata = (address == 3'd0) ? 32'(data) :
               (address == 3'd1) ? 32'(blink_en) :
               (address == 3'd2) ? 32'(period) :
               (address == 3'd5) ? {31'b0, phase} : 32'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data     <= RESET_VALUE;
      blink_en <= '0;
      period   <= '1;
      cnt      <= '0;
      phase    <= 1'b0;
      out_port <= RESET_VALUE;
    end else begin
      data     <= data_nxt;
      blink_en <= blink_nxt;
      period   <= period_nxt;
      cnt      <= cnt_nxt;
      phase    <= phase_nxt;
      out_port <= data_nxt & ~(blink_nxt & {WIDTH{phase_nxt}});
    end
  end
endmodule

// File: tb/tb_led_pio_blink.sv
// tb_led_pio_blink: randomized bench against an elapsed-time blink model plus directed literal checks.
module tb_led_pio_blink;
  localparam logic [8:0] RV = 9'h15A;
  logic clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write_n = 1'b1;
  logic [2:0] address = '0;
  logic [31:0] writedata = '0, readdata;
  logic [8:0] out_port;
  int total = 0, bad = 0;
  led_pio_blink #(.WIDTH(9), .RESET_VALUE(RV), .PERIOD_W(24)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );
  always #5 clk = ~clk;
  logic [8:0] m_data, m_blink;
  logic [23:0] m_per;
  longint t;
  bit mvalid = 0;
  // phase is derived from edges elapsed since the last timer restart
  function automatic logic m_phase();
    return logic'((t / (longint'(m_per) + 1)) % 2);
  endfunction
  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    case (a)
      3'd0: return {23'b0, m_data};
      3'd1: return {23'b0, m_blink};
      3'd2: return {8'b0, m_per};
      3'd5: return {31'b0, m_phase()};
      default: return 32'b0;
    endcase
  endfunction
  always @(posedge clk) begin
    if (reset) begin
      m_data = RV; m_blink = '0; m_per = '1; t = 0; mvalid = 1;
    end else begin
      t++;
      if (chipselect && !write_n)
        case (address)
          3'd0: m_data = writedata[8:0];
          3'd1: m_blink = writedata[8:0];
          3'd2: begin m_per = writedata[23:0]; t = 0; end
          3'd3: m_data = m_data | writedata[8:0];
          3'd4: m_data = m_data & ~writedata[8:0];
          default: ;
        endcase
    end
  end
  always @(negedge clk) begin
    if (mvalid) begin
      logic [8:0] eo;
      eo = m_phase() ? (m_data & ~m_blink) : m_data;
      total++;
      if (out_port !== eo) begin
        bad++; $display("FAIL model_out t=%0t: got %h want %h", $time, out_port, eo);
      end
      total++;
      if (readdata !== exp_rd(address)) begin
        bad++; $display("FAIL model_rd addr=%0d t=%0t: got %h want %h", address, $time, readdata, exp_rd(address));
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++; $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic step(input bit rs, input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] d);
    reset = rs; chipselect = cs; write_n = wn; address = a; writedata = d;
    @(posedge clk); #2;
    reset = 0; chipselect = 0; write_n = 1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(0, 1, 0, a, d);
  endtask
  task automatic idle();
    step(0, 0, 1, address, 0);
  endtask
  task automatic rd(input string nm, input logic [2:0] a, input logic [31:0] exp);
    address = a; #1; chk(nm, readdata, exp);
  endtask
  logic [8:0] e31_out [8] = '{9'h101, 9'h101, 9'h101, 9'h100, 9'h100, 9'h100, 9'h100, 9'h101};
  logic e31_st [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
  initial begin
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    chk("rst_out", {23'b0, out_port}, {23'b0, RV});
    rd("rst_data", 0, {23'b0, RV});
    rd("rst_blink", 1, 0);
    rd("rst_period", 2, 32'h00FF_FFFF);
    rd("rst_status", 5, 0);
    wr(0, 32'h1A5);
    chk("data_out", {23'b0, out_port}, 32'h1A5);
    rd("data_rd", 0, 32'h1A5);
    wr(0, 32'hFFFF_FFFF);
    rd("data_trunc", 0, 32'h1FF);
    wr(2, 32'hFFFF_FFFF);
    rd("period_trunc", 2, 32'h00FF_FFFF);
    wr(0, 32'h0F0);
    wr(3, 32'h003);
    chk("outset", {23'b0, out_port}, 32'h0F3);
    wr(4, 32'h030);
    chk("outclear", {23'b0, out_port}, 32'h0C3);
    rd("rd_outset", 3, 0);
    rd("rd_outclear", 4, 0);
    wr(6, 32'h1FF);
    wr(5, 32'h1FF);
    rd("reserved_nowrite", 0, 32'h0C3);
    rd("rd_reserved", 7, 0);
    wr(0, 32'h101);
    wr(1, 32'h001);
    wr(2, 32'h3);
    chk("blink_start", {23'b0, out_port}, 32'h101);
    for (int k = 0; k < 8; k++) begin
      address = 5;
      idle();
      chk($sformatf("blink_out%0d", k), {23'b0, out_port}, {23'b0, e31_out[k]});
      rd($sformatf("blink_st%0d", k), 5, {31'b0, e31_st[k]});
    end
    wr(2, 32'h3);
    repeat (3) idle();
    wr(2, 32'h5);
    rd("perwr_nowrap", 5, 0);
    chk("perwr_out", {23'b0, out_port}, 32'h101);
    repeat (5) idle();
    rd("perwr_hold", 5, 0);
    idle();
    rd("perwr_toggle", 5, 1);
    chk("perwr_toggle_out", {23'b0, out_port}, 32'h100);
    wr(0, 32'h1FF);
    wr(1, 32'h1FF);
    wr(2, 32'h0);
    chk("fast_start", {23'b0, out_port}, 32'h1FF);
    for (int k = 0; k < 4; k++) begin
      idle();
      chk($sformatf("fast%0d", k), {23'b0, out_port}, (k % 2 == 0) ? 32'h000 : 32'h1FF);
    end
    wr(2, 32'h2);
    repeat (5) idle();
    step(1, 1, 0, 0, 32'h055);
    chk("rst_mid_out", {23'b0, out_port}, {23'b0, RV});
    rd("rst_mid_data", 0, {23'b0, RV});
    rd("rst_mid_blink", 1, 0);
    rd("rst_mid_period", 2, 32'h00FF_FFFF);
    rd("rst_mid_status", 5, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd2 && $urandom_range(0, 15) != 0) d = $urandom_range(0, 9);
      step($urandom_range(0, 99) == 0, 1'($urandom), $urandom_range(0, 2) == 0, a, d);
      address = 3'($urandom_range(0, 7));
    end
    repeat (2) idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
